// File: rtl/ntt_bf_unit.sv
// Radix-2 NTT/INTT butterfly: CT (u=a+wb, v=a-wb) or GS (u=a+b, v=(a-b)w) per beat, mod Q.
// Fixed latency MUL_LAT+2, one beat per cycle, built around a pipelined Montgomery multiplier.
module ntt_bf_unit #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned MWR2MM_D   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_gs,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] w,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_u,
  output logic [DATA_WIDTH-1:0] out_v
);

  localparam int unsigned W       = DATA_WIDTH;
  localparam int unsigned D       = MWR2MM_D;
  localparam int unsigned NDIG    = W / D;
  localparam int unsigned MUL_LAT = NDIG + 1;
  localparam int unsigned L       = MUL_LAT + 2;

  typedef logic [W-1:0] data_t;
  typedef logic [W+1:0] acc_t;

  localparam data_t QD = data_t'(Q);
  localparam acc_t  QA = acc_t'(Q);

  function automatic data_t mod_add(data_t x, data_t y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QD}) s = s - {1'b0, QD};
    return s[W-1:0];
  endfunction

  // Top bit of the (W+1)-bit difference is the sign; y may be Q (alias of 0).
  function automatic data_t mod_sub(data_t x, data_t y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, QD};
    return d[W-1:0];
  endfunction

  // D iterations of bit-serial Montgomery reduction; t stays below 2Q.
  function automatic acc_t mont_digit(acc_t t_in, logic [D-1:0] dig, data_t bb);
    acc_t t;
    t = t_in;
    for (int j = 0; j < int'(D); j++) begin
      if (dig[j]) t = t + acc_t'(bb);
      if (t[0]) t = t + QA;
      t = t >> 1;
    end
    return t;
  endfunction

  // S0 input mapping
  data_t x0_d, ma0_d;
  always_comb begin
    x0_d  = a;
    ma0_d = b;
    if (in_gs) begin
      x0_d  = mod_add(a, b);
      ma0_d = mod_sub(a, b);
    end
  end

  data_t x_q  [MUL_LAT+1];
  logic  gs_q [MUL_LAT+1];
  data_t ma_p [NDIG];
  data_t mb_p [NDIG];
  acc_t  t_q  [NDIG];
  acc_t  t_d  [NDIG];
  data_t p_q;

  for (genvar k = 0; k < int'(NDIG); k++) begin : g_mul
    acc_t t_in;
    if (k == 0) begin : g_first
      assign t_in = '0;
    end else begin : g_rest
      assign t_in = t_q[k-1];
    end
    assign t_d[k] = mont_digit(t_in, ma_p[k][k*D +: D], mb_p[k]);
  end

  // Datapath registers run every cycle and carry no reset.
  always_ff @(posedge clk) begin
    x_q[0]  <= x0_d;
    gs_q[0] <= in_gs;
    ma_p[0] <= ma0_d;
    mb_p[0] <= w;
    for (int k = 1; k <= int'(MUL_LAT); k++) begin
      x_q[k]  <= x_q[k-1];
      gs_q[k] <= gs_q[k-1];
    end
    for (int k = 1; k < int'(NDIG); k++) begin
      ma_p[k] <= ma_p[k-1];
      mb_p[k] <= mb_p[k-1];
    end
    for (int k = 0; k < int'(NDIG); k++) begin
      t_q[k] <= t_d[k];
    end
    p_q <= (t_q[NDIG-1] >= QA) ? data_t'(t_q[NDIG-1] - QA) : data_t'(t_q[NDIG-1]);
  end

  data_t u_d, v_d;
  always_comb begin
    u_d = mod_add(x_q[MUL_LAT], p_q);
    v_d = mod_sub(x_q[MUL_LAT], p_q);
    if (gs_q[MUL_LAT]) begin
      u_d = x_q[MUL_LAT];
      v_d = (p_q == QD) ? '0 : p_q;
    end
  end

  logic [L-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      out_u   <= '0;
      out_v   <= '0;
    end else begin
      valid_q <= {valid_q[L-2:0], in_valid};
      if (valid_q[L-2]) begin
        out_u <= u_d;
        out_v <= v_d;
      end
    end
  end

  assign out_valid = valid_q[L-1];

  a_in_range: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> (a < QD && b < QD && w < QD));

endmodule

// File: tb/tb_ntt_bf_unit.sv
// Directed and randomized checks of ntt_bf_unit for Q=3329, DATA_WIDTH=12 (latency 6).
module tb_ntt_bf_unit;

  localparam int DW  = 12;
  localparam int QM  = 3329;
  localparam int LAT = 6;
  localparam int RM  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_gs = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [DW-1:0] w = '0;
  logic          out_valid;
  logic [DW-1:0] out_u;
  logic [DW-1:0] out_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_bf_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_gs    (in_gs),
    .a        (a),
    .b        (b),
    .w        (w),
    .out_valid(out_valid),
    .out_u    (out_u),
    .out_v    (out_v)
  );

  // Reference butterfly with plain twiddle z (the DUT sees w = z*2^12 mod Q).
  function automatic void golden(input bit gs, input int ia, input int ib, input int z,
                                 output int eu, output int ev);
    int p, d;
    if (!gs) begin
      p  = (ib * z) % QM;
      eu = (ia + p) % QM;
      ev = (ia - p + QM) % QM;
    end else begin
      d  = (ia - ib + QM) % QM;
      eu = (ia + ib) % QM;
      ev = (d * z) % QM;
    end
  endfunction

  task automatic drive_random(output int eu, output int ev, input bit gs);
    int ia, ib, z;
    ia = $urandom_range(0, QM - 1);
    ib = $urandom_range(0, QM - 1);
    z  = $urandom_range(0, QM - 1);
    in_valid = 1'b1;
    in_gs    = gs;
    a        = DW'(ia);
    b        = DW'(ib);
    w        = DW'((z * RM) % QM);
    golden(gs, ia, ib, z, eu, ev);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_u !== '0) begin errors++; $display("FAIL reset_u: got %0d expected 0", out_u); end
    checks++;
    if (out_v !== '0) begin errors++; $display("FAIL reset_v: got %0d expected 0", out_v); end
    rst = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL idle_valid: got %b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_directed();
    bit gs_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int a_t  [5] = '{5, 5, 3328, 3328, 0};
    int b_t  [5] = '{7, 7, 3328, 3328, 0};
    int w_t  [5] = '{767, 767, 767, 767, 0};
    int u_t  [5] = '{12, 12, 3327, 3327, 0};
    int v_t  [5] = '{3327, 3327, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_gs = gs_t[i];
      a = DW'(a_t[i]); b = DW'(b_t[i]); w = DW'(w_t[i]);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 3 * LAT) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != LAT) begin
        errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
      checks++;
      if (out_u !== DW'(u_t[i])) begin
        errors++; $display("FAIL dir_u[%0d]: got %0d expected %0d", i, out_u, u_t[i]);
      end
      checks++;
      if (out_v !== DW'(v_t[i])) begin
        errors++; $display("FAIL dir_v[%0d]: got %0d expected %0d", i, out_v, v_t[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir_single[%0d]: got %b expected 0", i, out_valid);
      end
      checks++;
      if (out_u !== DW'(u_t[i]) || out_v !== DW'(v_t[i])) begin
        errors++;
        $display("FAIL dir_hold[%0d]: got %0d/%0d expected %0d/%0d",
                 i, out_u, out_v, u_t[i], v_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int eu [64];
    int ev [64];
    for (int cyc = 0; cyc < 64 + LAT + 2; cyc++) begin
      bit exp_valid;
      @(negedge clk);
      exp_valid = (cyc >= LAT) && (cyc - LAT < 64);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", cyc, out_valid, exp_valid);
      end
      if (exp_valid && out_valid === 1'b1) begin
        checks++;
        if (out_u !== DW'(eu[cyc-LAT]) || out_v !== DW'(ev[cyc-LAT])) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %0d/%0d expected %0d/%0d",
                   cyc - LAT, out_u, out_v, eu[cyc-LAT], ev[cyc-LAT]);
        end
      end
      if (cyc < 64) drive_random(eu[cyc], ev[cyc], 1'(cyc % 2));
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int du, dv, lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random(du, dv, 1'(i % 2));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_valid[%0d]: got %b expected 0", k, out_valid);
      end
    end
    checks++;
    if (out_u !== '0 || out_v !== '0) begin
      errors++; $display("FAIL rstmid_out: got %0d/%0d expected 0/0", out_u, out_v);
    end
    in_valid = 1'b1; in_gs = 1'b0; a = DW'(5); b = DW'(7); w = DW'(767);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT || out_u !== DW'(12) || out_v !== DW'(3327)) begin
      errors++;
      $display("FAIL rstmid_next: got lat=%0d %0d/%0d expected lat=%0d 12/3327",
               lat, out_u, out_v, LAT);
    end
  endtask

  task automatic test_duty();
    bit hist [8192];
    int qu [$];
    int qv [$];
    int nb = 0;
    int stop_cyc = 8000;
    int last_u = 0, last_v = 0;
    bit seen = 1'b0;
    int cyc;
    for (cyc = 0; cyc < stop_cyc; cyc++) begin
      bit exp_valid;
      @(negedge clk);
      exp_valid = (cyc >= LAT) ? hist[cyc-LAT] : 1'b0;
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL duty_valid[%0d]: got %b expected %b", cyc, out_valid, exp_valid);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (qu.size() == 0) begin
          errors++; $display("FAIL duty_extra[%0d]: got valid expected none", cyc);
        end else begin
          last_u = qu.pop_front();
          last_v = qv.pop_front();
          seen   = 1'b1;
          if (out_u !== DW'(last_u) || out_v !== DW'(last_v)) begin
            errors++;
            $display("FAIL duty_data[%0d]: got %0d/%0d expected %0d/%0d",
                     cyc, out_u, out_v, last_u, last_v);
          end
        end
      end else if (seen) begin
        checks++;
        if (out_u !== DW'(last_u) || out_v !== DW'(last_v)) begin
          errors++;
          $display("FAIL duty_hold[%0d]: got %0d/%0d expected %0d/%0d",
                   cyc, out_u, out_v, last_u, last_v);
        end
      end
      if (nb < 1000 && $urandom_range(0, 99) < 30) begin
        int eu, ev;
        drive_random(eu, ev, 1'($urandom_range(0, 1)));
        qu.push_back(eu);
        qv.push_back(ev);
        hist[cyc] = 1'b1;
        nb++;
        if (nb == 1000) stop_cyc = cyc + LAT + 3;
      end else begin
        in_valid = 1'b0;
        hist[cyc] = 1'b0;
      end
    end
    checks++;
    if (nb != 1000 || qu.size() != 0) begin
      errors++; $display("FAIL duty_count: got %0d beats %0d pending expected 1000 0",
                         nb, qu.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_duty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
